// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory req/ack access with byte/half lane steering and load extension,
// a timeout watchdog on the ack, and the registered MEM/WB outputs.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MEM_aluResult,
  input  logic [1:0]  MEM_RegDst,
  input  logic [1:0]  MEM_RegSrc,
  input  logic [1:0]  MEM_MemOp,
  input  logic        MEM_MemEXT,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemRead,
  input  logic [31:0] MEM_rfOut2,
  input  logic [31:0] MEM_rd,
  input  logic [31:0] MEM_rt,
  input  logic [31:0] MEM_PC,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic [31:0] WB_aluResult,
  output logic [31:0] WB_memData,
  output logic [1:0]  WB_RegSrc,
  output logic [31:0] WB_PC,
  output logic [4:0]  WB_wreg,
  output logic        WB_RegWrite,
  output logic        addr_err,
  output logic        bus_err,
  output logic        debug_state
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  // Memory handshake: dm_req is held high from issue until the cycle dm_ack is seen (or the
  // watchdog expires); the access completes on the edge where dm_req & dm_ack are both high.
  // An ack without a request is ignored. Upstream holds the MEM_* inputs while mem_stall is high.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          req_raw;
  logic          timeout;

  logic        is_half, is_byte, is_word;
  logic        access, misaligned, is_load;
  logic [4:0]  wreg;
  logic        reg_write;
  logic [31:0] lane_shift;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic        unused_bits;

  assign unused_bits = ^{MEM_rd[31:5], MEM_rt[31:5]};

  assign is_half    = (MEM_MemOp == 2'b01);
  assign is_byte    = (MEM_MemOp == 2'b10);
  assign is_word    = ~is_half & ~is_byte;
  assign access     = MEM_MemRead | MEM_MemWrite;
  assign misaligned = access & ((is_half & MEM_aluResult[0]) |
                                (is_word & (MEM_aluResult[1:0] != 2'b00)));
  assign is_load    = MEM_MemRead & ~MEM_MemWrite & ~misaligned;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_raw   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (access && !misaligned) begin
          req_raw = 1'b1;
          if (!dm_ack) begin
            state_nxt = WAIT;
            cnt_nxt   = CW'(1);
          end
        end
      end
      WAIT: begin
        req_raw = 1'b1;
        if (dm_ack) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LAST_CNT) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Reset must drop the request at once, even though IDLE would otherwise re-issue from held inputs.
  assign dm_req      = req_raw & rst_n;
  assign mem_stall   = dm_req & ~dm_ack;
  assign dm_we       = dm_req & MEM_MemWrite;
  assign dm_addr     = {MEM_aluResult[31:2], 2'b00};
  assign debug_state = (state == WAIT);

  always_comb begin
    dm_be    = 4'b1111;
    dm_wdata = MEM_rfOut2;
    if (is_half) begin
      dm_be    = MEM_aluResult[1] ? 4'b1100 : 4'b0011;
      dm_wdata = {2{MEM_rfOut2[15:0]}};
    end else if (is_byte) begin
      dm_be    = 4'b0001 << MEM_aluResult[1:0];
      dm_wdata = {4{MEM_rfOut2[7:0]}};
    end
  end

  assign lane_shift = dm_rdata >> {MEM_aluResult[1:0], 3'b000};
  assign half_lane  = MEM_aluResult[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    load_data = dm_rdata;
    if (is_half) begin
      load_data = {{16{MEM_MemEXT & half_lane[15]}}, half_lane};
    end else if (is_byte) begin
      load_data = {{24{MEM_MemEXT & lane_shift[7]}}, lane_shift[7:0]};
    end
  end

  always_comb begin
    case (MEM_RegDst)
      2'b00:   wreg = MEM_rt[4:0];
      2'b01:   wreg = MEM_rd[4:0];
      2'b10:   wreg = 5'd31;
      default: wreg = 5'd0;
    endcase
  end

  assign reg_write = (MEM_RegDst != 2'b11) & ~MEM_MemWrite & ~misaligned & ~timeout &
                     (wreg != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_aluResult <= '0;
      WB_memData   <= '0;
      WB_RegSrc    <= '0;
      WB_PC        <= '0;
      WB_wreg      <= '0;
      WB_RegWrite  <= 1'b0;
      addr_err     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      addr_err <= misaligned & (state == IDLE);
      bus_err  <= timeout;
      if (mem_stall) begin
        WB_aluResult <= '0;
        WB_memData   <= '0;
        WB_RegSrc    <= '0;
        WB_PC        <= '0;
        WB_wreg      <= '0;
        WB_RegWrite  <= 1'b0;
      end else begin
        WB_aluResult <= MEM_aluResult;
        WB_memData   <= is_load ? load_data : 32'd0;
        WB_RegSrc    <= MEM_RegSrc;
        WB_PC        <= MEM_PC;
        WB_wreg      <= wreg;
        WB_RegWrite  <= reg_write;
      end
    end
  end

endmodule
